// File: rtl/sobel_rgb_green_outline_edge_overlay_pkg.sv
// Shared widths, colour and clamp constants for the Sobel green-outline overlay.
// Optional edge counter is compiled in with SOBEL_RGB_GREEN_OUTLINE_EDGE_COUNT_EN.
package sobel_rgb_green_outline_edge_overlay_pkg;

  localparam int GRAD_W_DEF = 11;
  localparam int PIX_W_DEF  = 24;
  localparam int MAG_W_DEF  = 22;

  localparam logic [PIX_W_DEF-1:0] GREEN_PIX = 24'h00FF00;

  // Most negative gradient is folded onto its neighbour so |g| fits GRAD_W-1 bits.
  function automatic int grad_clamp_lo(input int w);
    return -((1 << (w - 1)) - 1);
  endfunction

  localparam int GRAD_CLAMP = grad_clamp_lo(GRAD_W_DEF);

endpackage

// File: rtl/sobel_rgb_green_outline_edge_overlay_if.sv
// Stream interface: gradient/pixel beats in, overlaid pixel beats out, plus frame threshold.
interface sobel_rgb_green_outline_edge_overlay_if
  import sobel_rgb_green_outline_edge_overlay_pkg::*;
#(
  parameter int GRAD_W = GRAD_W_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int MAG_W  = MAG_W_DEF
) ();

  logic                     s_valid;
  logic                     s_ready;
  logic signed [GRAD_W-1:0] s_gx;
  logic signed [GRAD_W-1:0] s_gy;
  logic [PIX_W-1:0]         s_rgb;
  logic                     s_user;
  logic                     s_last;
  logic [MAG_W-1:0]         threshold;

  logic                     m_valid;
  logic                     m_ready;
  logic [PIX_W-1:0]         m_rgb;
  logic                     m_user;
  logic                     m_last;
  logic                     m_edge;

  modport slave (
    input  s_valid, s_gx, s_gy, s_rgb, s_user, s_last, threshold, m_ready,
    output s_ready, m_valid, m_rgb, m_user, m_last, m_edge
  );

  modport master (
    output s_valid, s_gx, s_gy, s_rgb, s_user, s_last, threshold, m_ready,
    input  s_ready, m_valid, m_rgb, m_user, m_last, m_edge
  );

endinterface

// File: rtl/sobel_rgb_green_outline_sq_stage.sv
// Two-register slice for one gradient: S1 clamps and registers it, S2 registers its square.
module sobel_rgb_green_outline_sq_stage
  import sobel_rgb_green_outline_edge_overlay_pkg::*;
#(
  parameter int GRAD_W = GRAD_W_DEF,
  parameter int SQ_W   = 2 * GRAD_W - 2
) (
  input  logic                     clk,
  input  logic                     adv,
  input  logic signed [GRAD_W-1:0] grad,
  output logic [SQ_W-1:0]          sq
);

  localparam logic signed [GRAD_W-1:0] CLAMP_LO = GRAD_W'(grad_clamp_lo(GRAD_W));

  logic signed [GRAD_W-1:0] grad_d, grad_q;
  logic [GRAD_W-2:0]        mag;
  logic [SQ_W-1:0]          sq_d, sq_q;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grad_d = grad_q;
    sq_d   = sq_q;
    mag    = grad_q[GRAD_W-1] ? (GRAD_W-1)'(-grad_q) : grad_q[GRAD_W-2:0];
    if (adv) begin
      grad_d = (grad < CLAMP_LO) ? CLAMP_LO : grad;
      sq_d   = SQ_W'(mag) * SQ_W'(mag);
    end
  end

  // NOTE: datapath flops have no reset; the valid bits in the parent qualify them, which keeps reset fan-out off the wide registers.
  // NOTE: clocked state is written with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    grad_q <= grad_d;
    sq_q   <= sq_d;
  end

  assign sq = sq_q;

endmodule

// File: rtl/sobel_rgb_green_outline_edge_overlay.sv
// 3-stage Sobel edge overlay: edges (gx^2+gy^2 >= threshold) are painted green.
// Define SOBEL_RGB_GREEN_OUTLINE_EDGE_COUNT_EN to add the per-frame edge_count output.
module sobel_rgb_green_outline_edge_overlay
  import sobel_rgb_green_outline_edge_overlay_pkg::*;
#(
  parameter int GRAD_W = GRAD_W_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int MAG_W  = MAG_W_DEF
) (
  input  logic                                   ap_clk,
  input  logic                                   ap_rst_n,
  sobel_rgb_green_outline_edge_overlay_if.slave  bus
`ifdef SOBEL_RGB_GREEN_OUTLINE_EDGE_COUNT_EN
  ,
  output logic [31:0]                            edge_count
`endif
);

  localparam int SQ_W = 2 * GRAD_W - 2;

  logic             adv;
  logic [SQ_W-1:0]  sq_x, sq_y;
  logic [MAG_W-1:0] sum;
  logic             edge_hit;

  logic             v1_d, v1_q, v2_d, v2_q;
  logic             m_valid_d, m_valid_q, m_edge_d, m_edge_q;
  logic             m_user_d, m_user_q, m_last_d, m_last_q;
  logic [PIX_W-1:0] m_rgb_d, m_rgb_q;
  logic [MAG_W-1:0] threshold_d, threshold_q;

  logic [PIX_W-1:0] rgb1_d, rgb1_q, rgb2_d, rgb2_q;
  logic             user1_d, user1_q, user2_d, user2_q;
  logic             last1_d, last1_q, last2_d, last2_q;
  logic [MAG_W-1:0] thr1_d, thr1_q, thr2_d, thr2_q;

  assign adv         = !m_valid_q || bus.m_ready;
  assign bus.s_ready = adv;

  sobel_rgb_green_outline_sq_stage #(.GRAD_W(GRAD_W), .SQ_W(SQ_W)) u_sq_x (
    .clk  (ap_clk),
    .adv  (adv),
    .grad (bus.s_gx),
    .sq   (sq_x)
  );

  sobel_rgb_green_outline_sq_stage #(.GRAD_W(GRAD_W), .SQ_W(SQ_W)) u_sq_y (
    .clk  (ap_clk),
    .adv  (adv),
    .grad (bus.s_gy),
    .sq   (sq_y)
  );

  assign sum      = MAG_W'(sq_x) + MAG_W'(sq_y);
  assign edge_hit = sum >= thr2_q;

  always_comb begin
    v1_d        = v1_q;
    v2_d        = v2_q;
    m_valid_d   = m_valid_q;
    m_edge_d    = m_edge_q;
    m_user_d    = m_user_q;
    m_last_d    = m_last_q;
    m_rgb_d     = m_rgb_q;
    threshold_d = threshold_q;
    rgb1_d      = rgb1_q;
    rgb2_d      = rgb2_q;
    user1_d     = user1_q;
    user2_d     = user2_q;
    last1_d     = last1_q;
    last2_d     = last2_q;
    thr1_d      = thr1_q;
    thr2_d      = thr2_q;
    if (adv) begin
      // The SOF beat carries its own fresh threshold so it never sees the stale one.
      if (bus.s_valid && bus.s_user) threshold_d = bus.threshold;
      v1_d      = bus.s_valid;
      rgb1_d    = bus.s_rgb;
      user1_d   = bus.s_user;
      last1_d   = bus.s_last;
      thr1_d    = bus.s_user ? bus.threshold : threshold_q;
      v2_d      = v1_q;
      rgb2_d    = rgb1_q;
      user2_d   = user1_q;
      last2_d   = last1_q;
      thr2_d    = thr1_q;
      m_valid_d = v2_q;
      m_edge_d  = v2_q && edge_hit;
      m_user_d  = v2_q && user2_q;
      m_last_d  = v2_q && last2_q;
      m_rgb_d   = !v2_q ? '0 : (edge_hit ? PIX_W'(GREEN_PIX) : rgb2_q);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      m_valid_q   <= 1'b0;
      m_edge_q    <= 1'b0;
      m_user_q    <= 1'b0;
      m_last_q    <= 1'b0;
      m_rgb_q     <= '0;
      threshold_q <= '1;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      m_valid_q   <= m_valid_d;
      m_edge_q    <= m_edge_d;
      m_user_q    <= m_user_d;
      m_last_q    <= m_last_d;
      m_rgb_q     <= m_rgb_d;
      threshold_q <= threshold_d;
    end
  end

  always_ff @(posedge ap_clk) begin
    rgb1_q  <= rgb1_d;
    rgb2_q  <= rgb2_d;
    user1_q <= user1_d;
    user2_q <= user2_d;
    last1_q <= last1_d;
    last2_q <= last2_d;
    thr1_q  <= thr1_d;
    thr2_q  <= thr2_d;
  end

  assign bus.m_valid = m_valid_q;
  assign bus.m_edge  = m_edge_q;
  assign bus.m_user  = m_user_q;
  assign bus.m_last  = m_last_q;
  assign bus.m_rgb   = m_rgb_q;

`ifdef SOBEL_RGB_GREEN_OUTLINE_EDGE_COUNT_EN
  logic [31:0] run_cnt_d, run_cnt_q, edge_count_d, edge_count_q;

  // A transferred SOF beat closes the previous frame and opens the new count with itself.
  always_comb begin
    run_cnt_d    = run_cnt_q;
    edge_count_d = edge_count_q;
    if (m_valid_q && bus.m_ready) begin
      if (m_user_q) begin
        edge_count_d = run_cnt_q;
        run_cnt_d    = 32'(m_edge_q);
      end else begin
        run_cnt_d    = run_cnt_q + 32'(m_edge_q);
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      run_cnt_q    <= '0;
      edge_count_q <= '0;
    end else begin
      run_cnt_q    <= run_cnt_d;
      edge_count_q <= edge_count_d;
    end
  end

  assign edge_count = edge_count_q;
`endif

endmodule
